mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage LoongArch core; the receiving end of the EX→MEM bus and of the data-SRAM read path.
- Latches the 188-bit EX→MEM bus under valid/allowin handshake and consumes data_sram_rdata one cycle after the EX-stage request.
- Performs load byte/half selection with sign or zero extension, and forwards to WB plus a bypass bus to ID.
- Holds SRAM read data across WB back-pressure.

Parameters:
- BUS_EW, 188, EX→MEM bus width.
- BUS_WW, 182, MEM→WB bus width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ex_mem_valid  in  1  EX has a valid instruction
- mem_allowin  out  1  MEM can accept
- ex_mem_bus  in  188  {gr_we, res_from_mem, mem_type[2:0], addr_low2[1:0], dest[4:0], pc, inst, result, csr_we, csr_re, csr_num[13:0], csr_wmask, csr_wvalue}, MSB first
- data_sram_rdata  in  32  word read data, valid the cycle after request
- mem_wb_valid  out  1  MEM presents valid instruction to WB
- wb_allowin  in  1  WB can accept
- mem_wb_bus  out  182  {gr_we, dest, pc, inst, final_result, csr_we, csr_re, csr_num, csr_wmask, csr_wvalue}
- mem_id_bus  out  38  {mem_bypass, dest[4:0], final_result}
- mem_ale  out  1  misaligned-load flag (see Optional Feature)

Behaviour:
- Clock and reset: clk; reset resetn, synchronous, active-low.
- Handshake:
  - mem_ready_go = 1.
  - mem_wb_valid = mem_valid.
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
  - mem_valid <= 0 on reset; else if mem_allowin, mem_valid <= ex_mem_valid.
  - Bus register loads when ex_mem_valid & mem_allowin; it is not reset.
- Read-data hold:
  - first_cyc is set on every bus load and cleared on the following cycle.
  - On first_cyc, rdata_hold <= data_sram_rdata and eff_rdata = data_sram_rdata.
  - Otherwise eff_rdata = rdata_hold.
  - This guarantees correct load data across any number of WB stall cycles.
  - rdata_hold resets to 0.
- Load extraction:
  - Byte select by addr_low2: 00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24].
  - Half select by addr_low2[1]: 0→[15:0], 1→[31:16].
  - mem_type[1:0]: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
  - mem_type[2]=1 zero-extends; 0 sign-extends.
- final_result = res_from_mem ? load_data : result.
- mem_bypass = mem_valid & gr_we.
- mem_wb_bus gr_we field is passed unmodified; WB qualifies it with valid.
- Reset values:
  - mem_wb_valid = 0, mem_allowin = 1, mem_id_bus[37] = 0, mem_ale = 0.
  - Data fields of mem_wb_bus and mem_id_bus are don't-care while invalid.
- Boundary cases:
  - Simultaneous issue and retire: when wb_allowin and ex_mem_valid are both 1, the new instruction loads in the same cycle and first_cyc is re-armed.
  - Reset mid-stall: mem_valid clears and the held instruction is dropped.
  - Bubble: ex_mem_valid = 0 with mem_allowin = 1 gives mem_valid = 0; the bus register is unchanged.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Enabled: mem_ale = mem_valid & res_from_mem & ((half & addr_low2[0]) | (word & |addr_low2)).
  - When mem_ale = 1, gr_we in mem_wb_bus and mem_bypass are forced to 0.
- Disabled: mem_ale is tied to 0; no gating.

Test Plan:
- Byte load, signed and unsigned: ld.b, addr_low2 = 01, rdata = 0x12A4_8000. Requires final_result = 0xFFFF_FF80 for mem_type = 010 and 0x0000_0080 for mem_type = 110.
- Half load: mem_type = 001, addr_low2 = 10, rdata = 0x8001_7FFF → final_result = 0xFFFF_8001.
- Stall hold:
  - Stimulus: ld.w accepted with rdata = 0xDEAD_BEEF. wb_allowin = 0 for 3 cycles. rdata changes to 0x0 after the first cycle.
  - Required: final_result stays 0xDEAD_BEEF throughout, and mem_allowin = 0 during the stall.
- Non-load passthrough: res_from_mem = 0, result = 0x0000_1234, gr_we = 1, dest = 5 → mem_id_bus = {1, 5, 0x1234}. Back-to-back instructions with wb_allowin = 1 advance one per cycle.
- Reset mid-stall: resetn = 0 while mem_valid = 1 → next cycle mem_wb_valid = 0, mem_allowin = 1, mem_bypass = 0.
- With MEM_ALIGN_CHECK_EN: ld.w with addr_low2 = 10 → mem_ale = 1 and gr_we out = 0. Without the macro, the same stimulus gives mem_ale = 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX->MEM, SRAM read data, MEM->WB and MEM->ID signal bundle for mem_stage
interface mem_stage_if #(
    parameter int BUS_EW = 188,
    parameter int BUS_WW = 182
);
    logic              ex_mem_valid;
    logic              mem_allowin;
    logic [BUS_EW-1:0] ex_mem_bus;
    logic [31:0]       data_sram_rdata;
    logic              mem_wb_valid;
    logic              wb_allowin;
    logic [BUS_WW-1:0] mem_wb_bus;
    logic [37:0]       mem_id_bus;
    logic              mem_ale;

    // MEM stage view
    modport slave (
        input  ex_mem_valid,
        input  ex_mem_bus,
        input  data_sram_rdata,
        input  wb_allowin,
        output mem_allowin,
        output mem_wb_valid,
        output mem_wb_bus,
        output mem_id_bus,
        output mem_ale
    );

    // Surrounding pipeline (EX, SRAM, WB, ID) view
    modport master (
        output ex_mem_valid,
        output ex_mem_bus,
        output data_sram_rdata,
        output wb_allowin,
        input  mem_allowin,
        input  mem_wb_valid,
        input  mem_wb_bus,
        input  mem_id_bus,
        input  mem_ale
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch MEM stage with load extraction and read-data hold; MEM_ALIGN_CHECK_EN enables misaligned-load flag
module mem_stage #(
    parameter int BUS_EW = 188,
    parameter int BUS_WW = 182
) (
    input  logic         clk,
    input  logic         resetn,
    mem_stage_if.slave   io
);

    // EX->MEM bus layout, MSB first
    typedef struct packed {
        logic        gr_we;
        logic        res_from_mem;
        logic [2:0]  mem_type;
        logic [1:0]  addr_low2;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } ex_mem_t;

    // MEM->WB bus layout, MSB first
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] final_result;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } mem_wb_t;

    // mem_type[1:0] encodings; 2'b11 is reserved and decodes as word
    localparam logic [1:0] MT_WORD = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_BYTE = 2'b10;

    // MEM never stalls on its own
    localparam logic MEM_READY_GO = 1'b1;

    logic [BUS_EW-1:0] ex_mem_bus_w;
    logic [BUS_WW-1:0] mem_wb_bus_w;

    ex_mem_t     bus_q;
    ex_mem_t     bus_d;
    logic        mem_valid_q;
    logic        mem_valid_d;
    logic        first_cyc_q;
    logic        first_cyc_d;
    logic [31:0] rdata_hold_q;
    logic [31:0] rdata_hold_d;

    logic        mem_allowin;
    logic        bus_load;
    logic [31:0] eff_rdata;
    logic [7:0]  byte_data;
    logic [15:0] half_data;
    logic        sign_ext;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        ale;
    logic        gr_we_out;
    logic        mem_bypass;
    mem_wb_t     wb_fields;

    assign ex_mem_bus_w = io.ex_mem_bus;

    // Pipeline handshake: accept whenever empty or the current instruction retires this cycle
    always_comb begin
        mem_allowin = ~mem_valid_q | (MEM_READY_GO & io.wb_allowin);
        bus_load    = io.ex_mem_valid & mem_allowin;
    end

    // Next-state for valid, bus register, first-cycle marker and held read data
    always_comb begin
        mem_valid_d  = mem_valid_q;
        bus_d        = bus_q;
        first_cyc_d  = bus_load;
        rdata_hold_d = rdata_hold_q;
        if (mem_allowin) begin
            mem_valid_d = io.ex_mem_valid;
        end
        if (bus_load) begin
            bus_d = ex_mem_t'(ex_mem_bus_w);
        end
        // SRAM data is only valid in the cycle right after the request; capture it then
        if (first_cyc_q) begin
            rdata_hold_d = io.data_sram_rdata;
        end
    end

    // Control state and held read data with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            first_cyc_q  <= 1'b0;
            rdata_hold_q <= 32'h0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            first_cyc_q  <= first_cyc_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    // Bus payload register; contents are qualified by mem_valid_q so no reset needed
    always_ff @(posedge clk) begin
        bus_q <= bus_d;
    end

    // Effective read data: live SRAM output on the first cycle, held copy while stalled
    always_comb begin
        eff_rdata = first_cyc_q ? io.data_sram_rdata : rdata_hold_q;
    end

    // Byte and halfword lane selection from the effective read word
    always_comb begin
        byte_data = eff_rdata[7:0];
        case (bus_q.addr_low2)
            2'b00:   byte_data = eff_rdata[7:0];
            2'b01:   byte_data = eff_rdata[15:8];
            2'b10:   byte_data = eff_rdata[23:16];
            default: byte_data = eff_rdata[31:24];
        endcase
        half_data = bus_q.addr_low2[1] ? eff_rdata[31:16] : eff_rdata[15:0];
    end

    // Size decode with sign or zero extension, then choose load data vs ALU result
    always_comb begin
        sign_ext = ~bus_q.mem_type[2];
        case (bus_q.mem_type[1:0])
            MT_HALF: load_data = {{16{sign_ext & half_data[15]}}, half_data};
            MT_BYTE: load_data = {{24{sign_ext & byte_data[7]}}, byte_data};
            default: load_data = eff_rdata;
        endcase
        final_result = bus_q.res_from_mem ? load_data : bus_q.result;
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load detection; a faulting load must not write the register file
    always_comb begin
        ale = 1'b0;
        if (mem_valid_q && bus_q.res_from_mem) begin
            case (bus_q.mem_type[1:0])
                MT_HALF: ale = bus_q.addr_low2[0];
                MT_BYTE: ale = 1'b0;
                default: ale = |bus_q.addr_low2;
            endcase
        end
        gr_we_out  = bus_q.gr_we & ~ale;
        mem_bypass = mem_valid_q & bus_q.gr_we & ~ale;
    end
`else
    // Alignment checking absent: flag tied low, write enable passes through
    always_comb begin
        ale        = 1'b0;
        gr_we_out  = bus_q.gr_we;
        mem_bypass = mem_valid_q & bus_q.gr_we;
    end
`endif

    // Assemble the MEM->WB bus; gr_we is left unqualified, WB gates it with valid
    always_comb begin
        wb_fields.gr_we        = gr_we_out;
        wb_fields.dest         = bus_q.dest;
        wb_fields.pc           = bus_q.pc;
        wb_fields.inst         = bus_q.inst;
        wb_fields.final_result = final_result;
        wb_fields.csr_we       = bus_q.csr_we;
        wb_fields.csr_re       = bus_q.csr_re;
        wb_fields.csr_num      = bus_q.csr_num;
        wb_fields.csr_wmask    = bus_q.csr_wmask;
        wb_fields.csr_wvalue   = bus_q.csr_wvalue;
        mem_wb_bus_w           = BUS_WW'(wb_fields);
    end

    assign io.mem_allowin  = mem_allowin;
    assign io.mem_wb_valid = mem_valid_q;
    assign io.mem_wb_bus   = mem_wb_bus_w;
    assign io.mem_id_bus   = {mem_bypass, bus_q.dest, final_result};
    assign io.mem_ale      = ale;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;

    localparam logic [31:0] INST     = 32'h2880_0421;
    localparam logic [79:0] CSR_TAIL = {1'b0, 1'b1, 14'h0005, 32'hFFFF_0000, 32'h1234_5678};

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if #(.BUS_EW(188), .BUS_WW(182)) io();

    mem_stage #(.BUS_EW(188), .BUS_WW(182)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (io)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        gr_we;
        logic        rfm;
        logic [2:0]  mt;
        logic [1:0]  a;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] rdata;
        logic [31:0] exp_final;
        logic        exp_ale_en;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [181:0] act, input logic [181:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [187:0] mk_bus(input logic gw, input logic rfm, input logic [2:0] mt,
                                            input logic [1:0] a, input logic [4:0] d,
                                            input logic [31:0] pc, input logic [31:0] res);
        return {gw, rfm, mt, a, d, pc, INST, res, CSR_TAIL};
    endfunction

    function automatic logic [181:0] exp_wb(input logic gw, input logic [4:0] d,
                                            input logic [31:0] pc, input logic [31:0] fin);
        return {gw, d, pc, INST, fin, CSR_TAIL};
    endfunction

    initial begin
        logic exp_ale;
        logic [31:0] pc;

        vecs[0]  = '{1'b1, 1'b1, 3'b010, 2'b01, 5'd3,  32'h0,         32'h12A4_8000, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'b110, 2'b01, 5'd4,  32'h0,         32'h12A4_8000, 32'h0000_0080, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 3'b001, 2'b10, 5'd6,  32'h0,         32'h8001_7FFF, 32'hFFFF_8001, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'b101, 2'b00, 5'd8,  32'h0,         32'h8001_7FFF, 32'h0000_7FFF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'b010, 2'b11, 5'd10, 32'h0,         32'h7F00_0000, 32'h0000_007F, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'b010, 2'b10, 5'd11, 32'h0,         32'h00FE_0000, 32'hFFFF_FFFE, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'b000, 2'b00, 5'd12, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'b011, 2'b00, 5'd13, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 2'b00, 5'd5,  32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'b000, 2'b10, 5'd14, 32'h0,         32'h1122_3344, 32'h1122_3344, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 3'b001, 2'b01, 5'd15, 32'h0,         32'h0000_ABCD, 32'hFFFF_ABCD, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 3'b000, 2'b11, 5'd16, 32'hA5A5_0001, 32'h0,         32'hA5A5_0001, 1'b0};

        resetn             = 1'b0;
        io.ex_mem_valid    = 1'b0;
        io.ex_mem_bus      = '0;
        io.data_sram_rdata = 32'h0;
        io.wb_allowin      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   {181'b0, io.mem_wb_valid},   182'd0);
        check("rst_allowin", {181'b0, io.mem_allowin},    182'd1);
        check("rst_bypass",  {181'b0, io.mem_id_bus[37]}, 182'd0);
        check("rst_ale",     {181'b0, io.mem_ale},        182'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {181'b0, io.mem_wb_valid}, 182'd0);

        // Single-instruction vectors, each followed by a bubble
        for (int i = 0; i < 12; i++) begin
`ifdef MEM_ALIGN_CHECK_EN
            exp_ale = vecs[i].exp_ale_en;
`else
            exp_ale = 1'b0;
`endif
            pc = 32'h1C00_0000 + 32'(i * 4);
            @(negedge clk);
            io.ex_mem_valid    = 1'b1;
            io.wb_allowin      = 1'b1;
            io.ex_mem_bus      = mk_bus(vecs[i].gr_we, vecs[i].rfm, vecs[i].mt, vecs[i].a,
                                        vecs[i].dest, pc, vecs[i].result);
            io.data_sram_rdata = 32'h5A5A_5A5A;
            @(posedge clk);
            #1;
            io.ex_mem_valid    = 1'b0;
            io.ex_mem_bus      = '0;
            io.data_sram_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_valid", i), {181'b0, io.mem_wb_valid}, 182'd1);
            check($sformatf("v%0d_wb_bus", i), io.mem_wb_bus,
                  exp_wb(vecs[i].gr_we & ~exp_ale, vecs[i].dest, pc, vecs[i].exp_final));
            check($sformatf("v%0d_id_bus", i), {144'b0, io.mem_id_bus},
                  {144'b0, vecs[i].gr_we & ~exp_ale, vecs[i].dest, vecs[i].exp_final});
            check($sformatf("v%0d_ale", i), {181'b0, io.mem_ale}, {181'b0, exp_ale});
            @(negedge clk);
            check($sformatf("v%0d_bubble", i), {181'b0, io.mem_wb_valid}, 182'd0);
        end

        // Stall hold: load data must survive WB back-pressure after SRAM output changes
        @(negedge clk);
        io.ex_mem_valid = 1'b1;
        io.wb_allowin   = 1'b1;
        io.ex_mem_bus   = mk_bus(1'b1, 1'b1, 3'b000, 2'b00, 5'd7, 32'h1C00_0100, 32'h0);
        @(posedge clk);
        #1;
        io.ex_mem_valid    = 1'b0;
        io.data_sram_rdata = 32'hDEAD_BEEF;
        io.wb_allowin      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_final", k), {150'b0, io.mem_wb_bus[111:80]}, {150'b0, 32'hDEAD_BEEF});
            check($sformatf("stall%0d_allowin", k), {181'b0, io.mem_allowin}, 182'd0);
            check($sformatf("stall%0d_valid", k), {181'b0, io.mem_wb_valid}, 182'd1);
            @(posedge clk);
            #1;
            io.data_sram_rdata = 32'h0;
        end
        io.wb_allowin = 1'b1;
        @(negedge clk);
        check("stall_release_final", {150'b0, io.mem_wb_bus[111:80]}, {150'b0, 32'hDEAD_BEEF});
        check("stall_release_allowin", {181'b0, io.mem_allowin}, 182'd1);
        @(negedge clk);
        check("stall_drain_valid", {181'b0, io.mem_wb_valid}, 182'd0);

        // Back-to-back with a one-cycle stall, then simultaneous issue and retire
        @(negedge clk);
        io.ex_mem_valid = 1'b1;
        io.wb_allowin   = 1'b1;
        io.ex_mem_bus   = mk_bus(1'b1, 1'b1, 3'b000, 2'b00, 5'd1, 32'h1C00_0200, 32'h0);
        @(posedge clk);
        #1;
        io.ex_mem_bus      = mk_bus(1'b1, 1'b1, 3'b110, 2'b11, 5'd2, 32'h1C00_0204, 32'h0);
        io.data_sram_rdata = 32'h1111_1111;
        io.wb_allowin      = 1'b0;
        @(negedge clk);
        check("b2b_a_final", {150'b0, io.mem_wb_bus[111:80]}, {150'b0, 32'h1111_1111});
        check("b2b_a_blocked", {181'b0, io.mem_allowin}, 182'd0);
        @(posedge clk);
        #1;
        io.data_sram_rdata = 32'hFFFF_FFFF;
        io.wb_allowin      = 1'b1;
        @(negedge clk);
        check("b2b_a_hold", {150'b0, io.mem_wb_bus[111:80]}, {150'b0, 32'h1111_1111});
        check("b2b_a_allowin", {181'b0, io.mem_allowin}, 182'd1);
        @(posedge clk);
        #1;
        io.ex_mem_bus      = mk_bus(1'b1, 1'b0, 3'b000, 2'b00, 5'd3, 32'h1C00_0208, 32'h0000_C0DE);
        io.data_sram_rdata = 32'hAB00_0000;
        @(negedge clk);
        check("b2b_b_final", {150'b0, io.mem_wb_bus[111:80]}, {150'b0, 32'h0000_00AB});
        check("b2b_b_id", {144'b0, io.mem_id_bus}, {144'b0, 1'b1, 5'd2, 32'h0000_00AB});
        check("b2b_b_pc", {150'b0, io.mem_wb_bus[175:144]}, {150'b0, 32'h1C00_0204});
        @(posedge clk);
        #1;
        io.ex_mem_valid    = 1'b0;
        io.data_sram_rdata = 32'h0;
        @(negedge clk);
        check("b2b_c_id", {144'b0, io.mem_id_bus}, {144'b0, 1'b1, 5'd3, 32'h0000_C0DE});
        @(negedge clk);
        check("b2b_drain_valid", {181'b0, io.mem_wb_valid}, 182'd0);

        // Reset while a held instruction is stalled
        @(negedge clk);
        io.ex_mem_valid = 1'b1;
        io.wb_allowin   = 1'b1;
        io.ex_mem_bus   = mk_bus(1'b1, 1'b1, 3'b000, 2'b00, 5'd9, 32'h1C00_0300, 32'h0);
        @(posedge clk);
        #1;
        io.ex_mem_valid    = 1'b0;
        io.wb_allowin      = 1'b0;
        io.data_sram_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("rstmid_pre_valid", {181'b0, io.mem_wb_valid}, 182'd1);
        check("rstmid_pre_bypass", {181'b0, io.mem_id_bus[37]}, 182'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("rstmid_valid",   {181'b0, io.mem_wb_valid},   182'd0);
        check("rstmid_allowin", {181'b0, io.mem_allowin},    182'd1);
        check("rstmid_bypass",  {181'b0, io.mem_id_bus[37]}, 182'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rstmid_after_valid", {181'b0, io.mem_wb_valid}, 182'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
